// File: rtl/mux_n_pipe.sv
// N-input registered multiplexer: explicit select or round-robin arbitration into a one-entry output stage.
// Latency: one cycle from input transfer to out_valid; sustains one word per cycle while out_ready is high.
// Backpressure: a stalled output holds its word and every in_ready stays low until the entry can be reloaded.
module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_src
);

    localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

    logic [SELW-1:0]  ptr;
    logic             load_en;
    logic             sel_in_range;
    logic             rr_vld;
    logic [SELW-1:0]  rr_idx;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_dat;

    assign load_en      = !out_valid || out_ready;
    assign sel_in_range = {1'b0, sel} < N_EXT;

    // Scan starts one past the last winner, so the last winner is examined last.
    always_comb begin : rr_scan
        logic [SELW-1:0] scan_idx;
        rr_vld   = 1'b0;
        rr_idx   = ptr;
        scan_idx = ptr;
        for (int k = 0; k < N; k++) begin
            scan_idx = (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
            if (!rr_vld && in_valid[scan_idx]) begin
                rr_vld = 1'b1;
                rr_idx = scan_idx;
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (mode) begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end else begin
            grant_vld = sel_in_range && in_valid[sel];
            grant_idx = sel;
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (rst_n && load_en && grant_vld && (grant_idx == SELW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_dat = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // ptr resets to the last channel so channel 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= LAST;
        end else if (|in_ready) begin
            out_valid <= 1'b1;
            out_data  <= grant_dat;
            out_src   <= grant_idx;
            ptr       <= grant_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: a 4x32 and a 3x8 instance driven in lockstep, each checked against a transaction-level model.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mode   [2];
    logic [1:0]  sel    [2];
    logic [3:0]  valid  [2];
    logic        oready [2];
    logic [31:0] data   [2][4];

    logic [3:0]  ir_a;
    logic [31:0] od_a;
    logic        ov_a;
    logic [1:0]  os_a;
    logic [2:0]  ir_b;
    logic [7:0]  od_b;
    logic        ov_b;
    logic [1:0]  os_b;

    mux_n_pipe #(.WIDTH(32), .N(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode[0]), .sel(sel[0]),
        .in_data({data[0][3], data[0][2], data[0][1], data[0][0]}),
        .in_valid(valid[0]), .in_ready(ir_a),
        .out_data(od_a), .out_valid(ov_a), .out_ready(oready[0]), .out_src(os_a)
    );

    mux_n_pipe #(.WIDTH(8), .N(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode[1]), .sel(sel[1]),
        .in_data({data[1][2][7:0], data[1][1][7:0], data[1][0][7:0]}),
        .in_valid(valid[1][2:0]), .in_ready(ir_b),
        .out_data(od_b), .out_valid(ov_b), .out_ready(oready[1]), .out_src(os_b)
    );

    int checks;
    int failures;

    // Reference model state per instance
    int          nch  [2] = '{4, 3};
    logic [31:0] dmask[2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    int          m_ptr[2];
    logic        m_ov [2];
    logic [31:0] m_od [2];
    int          m_os [2];
    bit          known;

    function automatic int exp_grant(int d);
        int n;
        int c;
        n = nch[d];
        if (!mode[d]) begin
            if (int'(sel[d]) < n && valid[d][sel[d]]) return int'(sel[d]);
            return -1;
        end
        for (int k = 1; k <= n; k++) begin
            c = (m_ptr[d] + k) % n;
            if (valid[d][c]) return c;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int         g  [2];
        logic [3:0] er [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            g[d]  = exp_grant(d);
            er[d] = (rst_n && (!m_ov[d] || oready[d]) && g[d] >= 0) ? 4'(1 << g[d]) : 4'b0;
        end
        check("a_in_ready", {28'b0, ir_a}, {28'b0, er[0]});
        check("b_in_ready", {29'b0, ir_b}, {28'b0, er[1]});
        if (known) begin
            check("a_out_valid", {31'b0, ov_a}, {31'b0, m_ov[0]});
            check("a_out_data",  od_a,          m_od[0]);
            check("a_out_src",   {30'b0, os_a}, 32'(m_os[0]));
            check("b_out_valid", {31'b0, ov_b}, {31'b0, m_ov[1]});
            check("b_out_data",  {24'b0, od_b}, m_od[1]);
            check("b_out_src",   {30'b0, os_b}, 32'(m_os[1]));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_ov[d]  = 1'b0;
                m_od[d]  = '0;
                m_os[d]  = 0;
                m_ptr[d] = nch[d] - 1;
            end else if (er[d] != 4'b0) begin
                m_od[d]  = data[d][g[d]] & dmask[d];
                m_os[d]  = g[d];
                m_ov[d]  = 1'b1;
                m_ptr[d] = g[d];
            end else if (m_ov[d] && oready[d]) begin
                m_ov[d] = 1'b0;
            end
        end
        if (!rst_n) known = 1'b1;
        #1;
    endtask

    task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
        for (int d = 0; d < 2; d++) begin
            mode[d]   = m;
            sel[d]    = s;
            valid[d]  = v;
            oready[d] = r;
        end
    endtask

    task automatic set_data(input int ch, input logic [31:0] val);
        data[0][ch] = val;
        data[1][ch] = val;
    endtask

    initial begin
        logic [31:0] hold;
        checks   = 0;
        failures = 0;
        known    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 1'b0; m_od[d] = '0; m_os[d] = 0; m_ptr[d] = nch[d] - 1;
        end
        for (int i = 0; i < 4; i++) set_data(i, 32'h0);

        // Reset held for two cycles with every channel valid
        rst_n = 1'b0;
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        cycle();
        cycle();
        check("rst_out_data", od_a, 32'h0);
        check("rst_out_valid", {31'b0, ov_a}, 32'h0);
        rst_n = 1'b1;
        cycle();
        check("first_rr_a", {30'b0, os_a}, 32'd0);
        check("first_rr_b", {30'b0, os_b}, 32'd0);

        // Explicit select
        set_data(2, 32'hDEAD_BEEF);
        drive(1'b0, 2'd2, 4'hF, 1'b1);
        cycle();
        check("sel2_data_a", od_a, 32'hDEAD_BEEF);
        check("sel2_src_a", {30'b0, os_a}, 32'd2);
        check("sel2_data_b", {24'b0, od_b}, 32'h0000_00EF);
        // sel 3: empty channel on A, out of range on B
        drive(1'b0, 2'd3, 4'b0111, 1'b1);
        cycle();
        check("bubble_a", {31'b0, ov_a}, 32'd0);
        check("bubble_b", {31'b0, ov_b}, 32'd0);
        cycle();

        // Round-robin from reset, all channels valid
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, 32'h100 + 32'(i));
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_src_a", {30'b0, os_a}, 32'(k % 4));
            check("rr_data_a", od_a, 32'h100 + 32'(k % 4));
            check("rr_src_b", {30'b0, os_b}, 32'(k % 3));
        end
        drive(1'b1, 2'd0, 4'b1010, 1'b1);
        for (int k = 0; k < 4; k++) cycle();

        // Backpressure: held word survives sel/data toggling
        drive(1'b0, 2'd1, 4'hF, 1'b1);
        set_data(1, 32'hCAFE_0001);
        hold = 32'hCAFE_0001;
        cycle();
        drive(1'b0, 2'd1, 4'hF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            sel[0] = 2'(k); sel[1] = 2'(k);
            set_data(1, $urandom);
            set_data(0, $urandom);
            cycle();
            check("hold_data_a", od_a, hold);
            check("hold_src_a", {30'b0, os_a}, 32'd1);
        end
        oready[0] = 1'b1; oready[1] = 1'b1;
        cycle();
        cycle();

        // Randomised traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            for (int d = 0; d < 2; d++) begin
                mode[d]   = 1'($urandom_range(0, 1));
                sel[d]    = 2'($urandom_range(0, 3));
                valid[d]  = 4'($urandom_range(0, 15));
                oready[d] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 4; i++) data[d][i] = $urandom;
            end
            cycle();
        end

        // Reset during a stall discards the word and restores priority
        rst_n = 1'b1;
        drive(1'b0, 2'd2, 4'hF, 1'b1);
        cycle();
        drive(1'b0, 2'd2, 4'hF, 1'b0);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("stall_rst_valid_a", {31'b0, ov_a}, 32'd0);
        check("stall_rst_valid_b", {31'b0, ov_b}, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        cycle();
        check("post_rst_rr_a", {30'b0, os_a}, 32'd0);
        check("post_rst_rr_b", {30'b0, os_b}, 32'd0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
